// File: rtl/alufu_pipe.sv
// alufu_pipe: pipelined ALU functional unit with an in-order output queue.
// A single-cycle op sampled at issue edge S enters the queue at S; a multiply
// passes through MUL_STAGES registers and enters the queue MUL_STAGES edges later.
// Each queue head is offered to the CDB and to the ROB independently and pops
// once both have taken it.
// Build option: define ALUFU_PIPE_MUL_EN to build the multiplier for opcode D;
// otherwise opcode D is a single-cycle op returning 0.
module alufu_pipe #(
  parameter int WIDTH      = 8,
  parameter int ROBID_W    = 4,
  parameter int META_W     = 8,
  parameter int QDEPTH     = 4,
  parameter int MUL_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    input_transmit,
  input  logic [WIDTH-1:0]        operand,
  input  logic [1:0][WIDTH-1:0]   depvals,
  input  logic [META_W-1:0]       wbs,
  input  logic [META_W-1:0]       flags,
  input  logic [ROBID_W-1:0]      robid,
  input  logic                    cdb_transmit,
  output logic                    cdb_transmit_out,
  output logic [ROBID_W-1:0]      cdb_id,
  output logic [WIDTH-1:0]        cdb_val,
  input  logic                    rob_transmit,
  output logic                    rob_transmit_out,
  output logic [ROBID_W-1:0]      robid_out,
  output logic [META_W-1:0]       flags_out,
  output logic [META_W-1:0]       wbs_out,
  output logic [WIDTH-1:0]        value_out,
  output logic                    busy
);

  localparam int SH_W  = $clog2(WIDTH);
  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNT_W = $clog2(QDEPTH + 1);

  typedef struct packed {
    logic [ROBID_W-1:0] id;
    logic [META_W-1:0]  wbs;
    logic [META_W-1:0]  flags;
    logic [WIDTH-1:0]   val;
  } entry_t;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  logic             accept;
  logic [WIDTH-1:0] op_a, op_b;
  logic [3:0]       opc;
  logic [SH_W-1:0]  sh;
  logic [WIDTH-1:0] alu_res;
  logic             is_mul;
  logic             alu_wr;
  entry_t           alu_entry;

  logic             mul_wr;
  entry_t           mul_entry;

  entry_t           q_mem [QDEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr, alu_ptr;
  logic [CNT_W-1:0] q_cnt, credit;
  logic             cdb_done, rob_done;
  logic             head_v, cdb_hs, rob_hs, pop;
  entry_t           head;

  // Credit covers queued entries plus multiplies still in flight, so a
  // completion always finds a free slot.
  assign busy   = (credit >= CNT_W'(QDEPTH));
  assign accept = input_transmit && !busy;

  // Operand selection and single-cycle result.
  always_comb begin
    op_a = depvals[0];
    if (flags[2]) begin
      op_b = operand;
      opc  = flags[3] ? 4'h0 : 4'h4;
    end else begin
      op_b = depvals[1];
      opc  = operand[3:0];
    end
    sh      = op_b[SH_W-1:0];
    alu_res = '0;
    case (opc)
      4'h0: alu_res = op_a + op_b;
      4'h1: alu_res = op_a - op_b;
      4'h2: alu_res = op_a & op_b;
      4'h3: alu_res = op_a | op_b;
      4'h4: alu_res = op_a ^ op_b;
      4'h5: alu_res = ~(op_a | op_b);
      4'h6: alu_res = ~(op_a & op_b);
      4'h7: alu_res = ~(op_a ^ op_b);
      4'h8: alu_res = op_a << sh;
      4'h9: alu_res = op_a >> sh;
      4'hA: alu_res = WIDTH'($signed(op_a) >>> sh);
      4'hB: alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      4'hC: alu_res = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
      default: alu_res = '0;
    endcase
`ifdef ALUFU_PIPE_MUL_EN
    is_mul = (opc == 4'hD);
`else
    is_mul = 1'b0;
`endif
    alu_wr    = accept && !is_mul;
    alu_entry = '{id: robid, wbs: wbs, flags: flags, val: alu_res};
  end

`ifdef ALUFU_PIPE_MUL_EN
  entry_t                mul_q [MUL_STAGES];
  logic [MUL_STAGES-1:0] mul_v;
  logic [WIDTH-1:0]      mul_prod;

  assign mul_prod  = op_a * op_b;
  assign mul_wr    = mul_v[MUL_STAGES-1];
  assign mul_entry = mul_q[MUL_STAGES-1];

  // Multiply pipeline: valid bits are reset, payload just follows along.
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_v <= '0;
    end else begin
      mul_v[0] <= accept && is_mul;
      for (int i = 1; i < MUL_STAGES; i++) mul_v[i] <= mul_v[i-1];
    end
    mul_q[0] <= '{id: robid, wbs: wbs, flags: flags, val: mul_prod};
    for (int i = 1; i < MUL_STAGES; i++) mul_q[i] <= mul_q[i-1];
  end
`else
  assign mul_wr    = 1'b0;
  assign mul_entry = '0;
`endif

  // Head handshakes; a grant without a request does nothing.
  always_comb begin
    head_v           = (q_cnt != '0);
    head             = q_mem[rd_ptr];
    cdb_transmit_out = head_v && !cdb_done;
    rob_transmit_out = head_v && !rob_done;
    cdb_hs           = cdb_transmit_out && cdb_transmit;
    rob_hs           = rob_transmit_out && rob_transmit;
    pop              = head_v && (cdb_done || cdb_hs) && (rob_done || rob_hs);
    alu_ptr          = mul_wr ? ptr_inc(wr_ptr) : wr_ptr;
  end

  // Data outputs are forced to zero while the queue is empty.
  always_comb begin
    cdb_id    = head_v ? head.id    : '0;
    cdb_val   = head_v ? head.val   : '0;
    robid_out = head_v ? head.id    : '0;
    flags_out = head_v ? head.flags : '0;
    wbs_out   = head_v ? head.wbs   : '0;
    value_out = head_v ? head.val   : '0;
  end

  // Queue storage: a completing multiply takes the first slot, the
  // single-cycle result the one after it.
  always_ff @(posedge clk) begin
    if (mul_wr) q_mem[wr_ptr]  <= mul_entry;
    if (alu_wr) q_mem[alu_ptr] <= alu_entry;
  end

  // Pointers, occupancy, credit and per-head done bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      q_cnt    <= '0;
      credit   <= '0;
      cdb_done <= 1'b0;
      rob_done <= 1'b0;
    end else begin
      if (mul_wr && alu_wr)      wr_ptr <= ptr_inc(ptr_inc(wr_ptr));
      else if (mul_wr || alu_wr) wr_ptr <= ptr_inc(wr_ptr);
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      q_cnt  <= q_cnt + CNT_W'(mul_wr) + CNT_W'(alu_wr) - CNT_W'(pop);
      credit <= credit + CNT_W'(accept) - CNT_W'(pop);
      if (pop) begin
        cdb_done <= 1'b0;
        rob_done <= 1'b0;
      end else begin
        cdb_done <= cdb_done || cdb_hs;
        rob_done <= rob_done || rob_hs;
      end
    end
  end

endmodule

// File: tb/tb_alufu_pipe.sv
// Directed bench for alufu_pipe (WIDTH=8, QDEPTH=4, MUL_STAGES=1).
module tb_alufu_pipe;

  logic            clk = 1'b0;
  logic            rst;
  logic            input_transmit;
  logic [7:0]      operand;
  logic [1:0][7:0] depvals;
  logic [7:0]      wbs, flags;
  logic [3:0]      robid;
  logic            cdb_transmit, rob_transmit;
  logic            cdb_transmit_out, rob_transmit_out, busy;
  logic [3:0]      cdb_id, robid_out;
  logic [7:0]      cdb_val, flags_out, wbs_out, value_out;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alufu_pipe #(.WIDTH(8), .ROBID_W(4), .META_W(8), .QDEPTH(4), .MUL_STAGES(1)) dut (
    .clk(clk), .rst(rst), .input_transmit(input_transmit), .operand(operand),
    .depvals(depvals), .wbs(wbs), .flags(flags), .robid(robid),
    .cdb_transmit(cdb_transmit), .cdb_transmit_out(cdb_transmit_out),
    .cdb_id(cdb_id), .cdb_val(cdb_val), .rob_transmit(rob_transmit),
    .rob_transmit_out(rob_transmit_out), .robid_out(robid_out),
    .flags_out(flags_out), .wbs_out(wbs_out), .value_out(value_out), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [7:0] opd, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] fl, input logic [3:0] id);
    operand = opd; depvals[0] = a; depvals[1] = b; flags = fl; robid = id;
  endtask

  // Back-to-back vectors: operand, a, b, flags, expected value.
  logic [7:0] t_opd [10] = '{8'h01, 8'h0A, 8'h0B, 8'h0C, 8'h08, 8'h09, 8'h05, 8'h07, 8'h0E, 8'h05};
  logic [7:0] t_a   [10] = '{8'h10, 8'h80, 8'hFF, 8'hFF, 8'h81, 8'h81, 8'hF0, 8'hAA, 8'h12, 8'hFE};
  logic [7:0] t_b   [10] = '{8'h20, 8'h03, 8'h01, 8'h01, 8'h0B, 8'h03, 8'h0F, 8'h0F, 8'h34, 8'h77};
  logic [7:0] t_fl  [10] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0C};
  logic [7:0] t_exp [10] = '{8'hF0, 8'hF0, 8'h01, 8'h00, 8'h08, 8'h10, 8'h00, 8'h5A, 8'h00, 8'h03};

  initial begin
    rst = 1'b1; input_transmit = 1'b0; wbs = 8'h00;
    cdb_transmit = 1'b0; rob_transmit = 1'b0;
    set_in(8'h00, 8'h00, 8'h00, 8'h00, 4'h0);
    tick(); tick();
    chk("rst_cdb_req", cdb_transmit_out, 0);
    chk("rst_rob_req", rob_transmit_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", {cdb_id, cdb_val, robid_out, value_out}, 0);
    rst = 1'b0;

    // Add with both grants held high beforehand.
    cdb_transmit = 1'b1; rob_transmit = 1'b1; wbs = 8'hA5;
    set_in(8'h00, 8'hF0, 8'h20, 8'h00, 4'd3);
    input_transmit = 1'b1;
    tick();
    input_transmit = 1'b0;
    chk("add_cdb_req", cdb_transmit_out, 1);
    chk("add_cdb_id", cdb_id, 3);
    chk("add_cdb_val", cdb_val, 8'h10);
    chk("add_rob_req", rob_transmit_out, 1);
    chk("add_wbs", wbs_out, 8'hA5);
    tick();
    chk("add_popped", {cdb_transmit_out, rob_transmit_out}, 0);

    // Immediate xor, CDB grant in cycle +1, ROB grant in cycle +3.
    cdb_transmit = 1'b0; rob_transmit = 1'b0; wbs = 8'h00;
    set_in(8'h0F, 8'h55, 8'h00, 8'h04, 4'd5);
    input_transmit = 1'b1;
    tick();
    input_transmit = 1'b0;
    chk("xori_val", value_out, 8'h5A);
    chk("xori_flags", flags_out, 8'h04);
    cdb_transmit = 1'b1;
    tick();
    cdb_transmit = 1'b0;
    chk("xori_cdb_drop", cdb_transmit_out, 0);
    chk("xori_rob_req1", rob_transmit_out, 1);
    tick();
    chk("xori_hold_val", value_out, 8'h5A);
    chk("xori_rob_req2", rob_transmit_out, 1);
    rob_transmit = 1'b1;
    tick();
    rob_transmit = 1'b0;
    chk("xori_popped", rob_transmit_out, 0);

    // Back-to-back issue with grants high: one result per cycle.
    cdb_transmit = 1'b1; rob_transmit = 1'b1;
    input_transmit = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_in(t_opd[i], t_a[i], t_b[i], t_fl[i], 4'(i));
      tick();
      chk($sformatf("vec%0d_val", i), cdb_val, t_exp[i]);
      chk($sformatf("vec%0d_id", i), cdb_id, i);
    end
    input_transmit = 1'b0;
    tick();
    chk("b2b_empty", cdb_transmit_out, 0);

    // Multiply followed by an add on the next cycle.
    cdb_transmit = 1'b0; rob_transmit = 1'b0;
    set_in(8'h0D, 8'd7, 8'd9, 8'h00, 4'd1);
    input_transmit = 1'b1;
    tick();
    set_in(8'h00, 8'd1, 8'd1, 8'h00, 4'd2);
    tick();
    input_transmit = 1'b0;
    chk("mul_head_id", cdb_id, 1);
`ifdef ALUFU_PIPE_MUL_EN
    chk("mul_head_val", cdb_val, 8'd63);
`else
    chk("mul_head_val", cdb_val, 8'd0);
`endif
    cdb_transmit = 1'b1; rob_transmit = 1'b1;
    tick();
    chk("mul_next_id", cdb_id, 2);
    chk("mul_next_val", cdb_val, 8'd2);
    tick();
    chk("mul_empty", cdb_transmit_out, 0);

    // Fill the queue with grants low.
    cdb_transmit = 1'b0; rob_transmit = 1'b0;
    input_transmit = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_in(8'h00, 8'(i), 8'h01, 8'h00, 4'(8 + i));
      tick();
      chk($sformatf("fill%0d_busy", i), busy, (i == 3) ? 1 : 0);
    end
    set_in(8'h00, 8'h40, 8'h01, 8'h00, 4'd12);
    tick();
    input_transmit = 1'b0;
    chk("full_busy", busy, 1);
    chk("full_head", cdb_id, 8);
    cdb_transmit = 1'b1; rob_transmit = 1'b1;
    tick();
    chk("pop_busy", busy, 0);
    for (int i = 1; i < 4; i++) begin
      chk($sformatf("drain%0d_id", i), cdb_id, 8 + i);
      chk($sformatf("drain%0d_val", i), cdb_val, i + 1);
      tick();
    end
    chk("drain_empty", cdb_transmit_out, 0);

    // Reset with one queued entry and a multiply in flight.
    cdb_transmit = 1'b0; rob_transmit = 1'b0;
    set_in(8'h00, 8'h11, 8'h22, 8'h00, 4'd4);
    input_transmit = 1'b1;
    tick();
    set_in(8'h0D, 8'h03, 8'h05, 8'h00, 4'd6);
    tick();
    input_transmit = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_reqs", {cdb_transmit_out, rob_transmit_out}, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_data", {cdb_id, cdb_val, value_out}, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("no_stale%0d", i), {cdb_transmit_out, rob_transmit_out}, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
